// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake and status bundle of the UART receive FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] count;

  modport master (
    output data, valid, frame_err, overflow, count,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overflow, count,
    output ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 3-sample majority voting feeding a first-word
// fall-through FIFO; frame errors and FIFO overflow are reported as pulses.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RX,
  uart_rx_fifo_if.master  bus
);
  localparam int unsigned BCW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [BCW-1:0] HALF_RELOAD = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] FULL_RELOAD = BCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic           sync1_q, sync2_q;
  logic [1:0]     fill_q, fill_d;
  logic           armed_q, armed_d;
  state_t         state_q, state_d;
  logic [BCW-1:0] bit_clk_q, bit_clk_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [1:0]     samp_q, samp_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overflow_q, overflow_d;

  logic rxi, maj, push_c, ferr_c, pop_c, full_c, push_ok_c;

  assign rxi = sync2_q;
  assign maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxi) | (samp_q[0] & rxi);

  // Receiver next state: arming, bit timing, majority sampling, byte assembly.
  always_comb begin
    state_d   = state_q;
    bit_clk_d = bit_clk_q;
    bit_idx_d = bit_idx_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
    // Synchronizer flops reset to 1, so only trust RXi once both carry real line samples.
    fill_d    = {fill_q[0], 1'b1};
    armed_d   = armed_q | (fill_q[1] & rxi);

    if (state_q != IDLE) begin
      if (bit_clk_q == BCW'(2)) samp_d[1] = rxi;
      if (bit_clk_q == BCW'(1)) samp_d[0] = rxi;
    end

    case (state_q)
      IDLE: begin
        if (armed_q && !rxi) begin
          state_d   = START;
          bit_clk_d = HALF_RELOAD;
        end
      end
      START: begin
        if (bit_clk_q == '0) begin
          if (maj) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_clk_d = FULL_RELOAD;
            bit_idx_d = 3'd0;
          end
        end else begin
          bit_clk_d = bit_clk_q - BCW'(1);
        end
      end
      DATA: begin
        if (bit_clk_q == '0) begin
          shift_d[bit_idx_q] = maj;
          bit_clk_d          = FULL_RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_clk_d = bit_clk_q - BCW'(1);
        end
      end
      STOP: begin
        if (bit_clk_q == '0) begin
          if (maj) push_c = 1'b1;
          else     ferr_c = 1'b1;
          state_d = IDLE;
        end else begin
          bit_clk_d = bit_clk_q - BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO next state: push/pop arbitration, pointer wrap, registered head byte.
  always_comb begin
    pop_c     = valid_q & bus.ready;
    full_c    = (count_q == CW'(FIFO_DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d     = (count_d != '0);
    data_d      = valid_d ? mem_d[rd_ptr_d] : 8'h00;
    frame_err_d = ferr_c;
    overflow_d  = push_c & full_c & ~pop_c;
  end

  // All state registers; reset abandons any frame and empties the FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      fill_q      <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= IDLE;
      bit_clk_q   <= '0;
      bit_idx_q   <= 3'd0;
      samp_q      <= 2'b00;
      shift_q     <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= RX;
      sync2_q     <= sync1_q;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_clk_q   <= bit_clk_d;
      bit_idx_q   <= bit_idx_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
endmodule
